// File: rtl/wtree_final_adder.sv
// Final carry-propagate adder of the multiplier: resolves the Wallace-tree sum/carry
// pair over two valid/ready pipeline stages (low half, then high half with the registered carry).
// Optional macro WTREE_FINAL_ADDER_ZERO_FLAG_EN adds the registered out_zero result flag.
module wtree_final_adder #(
  parameter int WIDTH = 64,
  parameter int SPLIT = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int HW = WIDTH - SPLIT;

  // Stage 1 state
  logic             s1_valid_q,   s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q,      s1_lo_d;
  logic             s1_c1_q,      s1_c1_d;
  logic [HW-1:0]    s1_sum_hi_q,  s1_sum_hi_d;
  logic [HW-1:0]    s1_carry_hi_q, s1_carry_hi_d;

  // Stage 2 state
  logic             s2_valid_q,   s2_valid_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             cout_q,       cout_d;

`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
  logic             s1_lo_zero_q, s1_lo_zero_d;
  logic             zero_q,       zero_d;
`endif

  logic [SPLIT:0]   lo_sum;
  logic [HW:0]      hi_sum;
  logic             s2_can_load;
  logic             in_fire;
  logic             s1_adv;
  logic             out_fire;

  assign lo_sum = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
  assign hi_sum = {1'b0, s1_sum_hi_q} + {1'b0, s1_carry_hi_q} + {{HW{1'b0}}, s1_c1_q};

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign s2_can_load = !s2_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign in_fire     = in_valid && in_ready;
  assign s1_adv      = s1_valid_q && s2_can_load;
  assign out_fire    = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_lo_d       = s1_lo_q;
    s1_c1_d       = s1_c1_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_carry_hi_d = s1_carry_hi_q;
    s2_valid_d    = s2_valid_q;
    result_d      = result_q;
    cout_d        = cout_q;
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    s1_lo_zero_d  = s1_lo_zero_q;
    zero_d        = zero_q;
`endif

    if (in_fire) begin
      s1_valid_d    = 1'b1;
      s1_lo_d       = lo_sum[SPLIT-1:0];
      s1_c1_d       = lo_sum[SPLIT];
      s1_sum_hi_d   = in_sum[WIDTH-1:SPLIT];
      s1_carry_hi_d = in_carry[WIDTH-1:SPLIT];
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
      s1_lo_zero_d  = (lo_sum[SPLIT-1:0] == '0);
`endif
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Data registers only change on a load, so a stalled result stays put.
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      result_d   = {hi_sum[HW-1:0], s1_lo_q};
      cout_d     = hi_sum[HW];
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
      zero_d     = s1_lo_zero_q && (hi_sum[HW-1:0] == '0);
`endif
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; data registers are reset too because out_result must read 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c1_q       <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s2_valid_q    <= 1'b0;
      result_q      <= '0;
      cout_q        <= 1'b0;
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
      s1_lo_zero_q  <= 1'b0;
      zero_q        <= 1'b0;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_q       <= s1_lo_d;
      s1_c1_q       <= s1_c1_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_carry_hi_q <= s1_carry_hi_d;
      s2_valid_q    <= s2_valid_d;
      result_q      <= result_d;
      cout_q        <= cout_d;
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
      s1_lo_zero_q  <= s1_lo_zero_d;
      zero_q        <= zero_d;
`endif
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_cout   = cout_q;
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
  assign out_zero   = zero_q;
`endif

endmodule

// File: tb/tb_wtree_final_adder.sv
// Directed and randomized bench for wtree_final_adder: default 64/32 instance plus
// WIDTH=16 instances at SPLIT=1 and SPLIT=15. Honors WTREE_FINAL_ADDER_ZERO_FLAG_EN.
module tb_wtree_final_adder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_sum = '0;
  logic [63:0] in_carry = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_cout;

  logic        p_valid = 1'b0;
  logic        p_out_ready = 1'b1;
  logic [15:0] p_sum = '0;
  logic [15:0] p_carry = '0;
  logic        pa_in_ready, pa_out_valid, pa_cout;
  logic        pb_in_ready, pb_out_valid, pb_cout;
  logic [15:0] pa_result, pb_result;

`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
  logic        out_zero, pa_zero, pb_zero;
`endif

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        stall_prev = 1'b0;
  logic [64:0] prev_out = '0;
  logic        last_in_fire = 1'b0;

  always #5 clock = ~clock;

  wtree_final_adder #(.WIDTH(64), .SPLIT(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_cout(out_cout)
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  wtree_final_adder #(.WIDTH(16), .SPLIT(1)) dut_s1 (
    .clock(clock), .reset(reset),
    .in_valid(p_valid), .in_ready(pa_in_ready), .in_sum(p_sum), .in_carry(p_carry),
    .out_valid(pa_out_valid), .out_ready(p_out_ready), .out_result(pa_result), .out_cout(pa_cout)
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    , .out_zero(pa_zero)
`endif
  );

  wtree_final_adder #(.WIDTH(16), .SPLIT(15)) dut_s15 (
    .clock(clock), .reset(reset),
    .in_valid(p_valid), .in_ready(pb_in_ready), .in_sum(p_sum), .in_carry(p_carry),
    .out_valid(pb_out_valid), .out_ready(p_out_ready), .out_result(pb_result), .out_cout(pb_cout)
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    , .out_zero(pb_zero)
`endif
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at the falling edge, settle, then score the transfers
  // that the next rising edge will perform.
  task automatic step(input logic v, input logic [63:0] s, input logic [63:0] c,
                      input logic ordy);
    logic [64:0] e;
    @(negedge clock);
    if (stall_prev) begin
      check("stall_valid", {64'd0, out_valid}, 65'd1);
      check("stall_data", {out_cout, out_result}, prev_out);
    end
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = ordy;
    #1;
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) exp_q.push_back({1'b0, s} + {1'b0, c});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", {64'd0, out_valid}, 65'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {out_cout, out_result}, e);
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
        check("zero_flag", {64'd0, out_zero}, {64'd0, (e[63:0] == 64'd0)});
`endif
        got_q.push_back(out_result);
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_out   = {out_cout, out_result};
  endtask

  initial begin
    int k;
    int sent;
    int cyc;
    int bp_exp[4] = '{3, 6, 9, 12};
    logic bp_rdy[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] rs, rc;

    // Reset state
    @(negedge clock);
    check("rst_out_valid", {64'd0, out_valid}, 65'd0);
    check("rst_out_data", {out_cout, out_result}, 65'd0);
    check("rst_in_ready", {64'd0, in_ready}, 65'd1);
    reset = 1'b0;

    // Basic add crossing the split, 2-cycle latency
    step(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1);
    step(1'b0, 64'h0, 64'h0, 1'b1);
    check("basic_lat1_valid", {64'd0, out_valid}, 65'd0);
    step(1'b0, 64'h0, 64'h0, 1'b1);
    check("basic_valid", {64'd0, out_valid}, 65'd1);
    check("basic_data", {out_cout, out_result}, {1'b0, 64'h0000_0001_0000_0000});

    // Overflow wrap: result 0, carry out set
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    step(1'b0, 64'h0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 64'h0, 1'b1);
    check("ovf_valid", {64'd0, out_valid}, 65'd1);
    check("ovf_data", {out_cout, out_result}, {1'b1, 64'h0});
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    check("ovf_zero", {64'd0, out_zero}, 65'd1);
`endif
    step(1'b0, 64'h0, 64'h0, 1'b1);

    // Back-pressure: in_ready drops after two accepts
    got_q.delete();
    k = 1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 64'(k), 64'(k) << 1, 1'b0);
      check("bp_in_ready", {64'd0, in_ready}, {64'd0, bp_rdy[i]});
      if (last_in_fire) k++;
    end
    cyc = 0;
    while ((k <= 4 || exp_q.size() != 0) && cyc < 20) begin
      step(k <= 4, 64'(k), 64'(k) << 1, 1'b1);
      if (last_in_fire) k++;
      cyc++;
    end
    check("bp_drain_done", 65'(exp_q.size()), 65'd0);
    check("bp_count", 65'(got_q.size()), 65'd4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) check("bp_order", {1'b0, got_q[i]}, 65'(bp_exp[i]));

    // Random valid/ready traffic
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 6000) begin
      rs = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rc = ~rs;
        1: rc = -rs;
        2: begin rs = 64'hFFFF_FFFF_FFFF_FFFF; rc = 64'(($urandom_range(0, 2))); end
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, rs, rc, $urandom_range(0, 3) != 0);
      if (last_in_fire) sent++;
      cyc++;
    end
    check("rand_all_sent", 65'(sent), 65'd1000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(1'b0, 64'h0, 64'h0, 1'b1);
      cyc++;
    end
    check("rand_drain_done", 65'(exp_q.size()), 65'd0);

    // Asynchronous reset with two items in flight
    step(1'b1, 64'h1234, 64'h1, 1'b0);
    step(1'b1, 64'h5678, 64'h2, 1'b0);
    step(1'b0, 64'h0, 64'h0, 1'b0);
    check("full_in_ready", {64'd0, in_ready}, 65'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", {64'd0, out_valid}, 65'd0);
    check("arst_out_data", {out_cout, out_result}, 65'd0);
    check("arst_in_ready", {64'd0, in_ready}, 65'd1);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 64'h0, 64'h0, 1'b1);
      check("post_rst_no_stale", {64'd0, out_valid}, 65'd0);
    end
    check("post_rst_in_ready", {64'd0, in_ready}, 65'd1);

    // WIDTH=16 sweep at SPLIT=1 and SPLIT=15
    @(negedge clock);
    p_valid = 1'b1; p_sum = 16'h7FFF; p_carry = 16'h0001; p_out_ready = 1'b1;
    @(negedge clock);
    p_valid = 1'b0;
    @(negedge clock);
    check("w16_s1_valid", {64'd0, pa_out_valid}, 65'd1);
    check("w16_s1_data", {48'd0, pa_cout, pa_result}, {48'd0, 1'b0, 16'h8000});
    check("w16_s15_valid", {64'd0, pb_out_valid}, 65'd1);
    check("w16_s15_data", {48'd0, pb_cout, pb_result}, {48'd0, 1'b0, 16'h8000});
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    check("w16_s1_zero", {64'd0, pa_zero}, 65'd0);
    check("w16_s15_zero", {64'd0, pb_zero}, 65'd0);
`endif
    p_valid = 1'b1; p_sum = 16'hFFFF; p_carry = 16'h0001;
    @(negedge clock);
    p_valid = 1'b0;
    @(negedge clock);
    check("w16_s1_ovf", {48'd0, pa_cout, pa_result}, {48'd0, 1'b1, 16'h0000});
    check("w16_s15_ovf", {48'd0, pb_cout, pb_result}, {48'd0, 1'b1, 16'h0000});
`ifdef WTREE_FINAL_ADDER_ZERO_FLAG_EN
    check("w16_s1_ovf_zero", {64'd0, pa_zero}, 65'd1);
    check("w16_s15_ovf_zero", {64'd0, pb_zero}, 65'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wtree_final_adder.md
Name: wtree_final_adder

Overview:
- Final carry-propagate stage of the integer multiplier datapath.
- Consumes the redundant sum/carry vector pair produced by the chained Wallace-tree slices and resolves it into a binary product.
- Two-stage pipeline: low half in stage 1, high half in stage 2 using the registered carry.
- Sits between the compressor-tree array and the multiplier result register; valid/ready on both sides so downstream stalls back-pressure the tree.

Parameters:
- WIDTH, 64, operand/result width in bits; must be even, at least 4.
- SPLIT, 32, bit position of the pipeline cut; low adder covers [SPLIT-1:0]; 1 <= SPLIT < WIDTH.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sum/carry pair present.
- in_ready  output  1  block accepts the pair this cycle.
- in_sum  input  WIDTH  sum vector from the tree.
- in_carry  input  WIDTH  carry vector, already weight-aligned (shifted by the tree side).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_result  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_cout=0, all stage data registers 0. Takes effect immediately, mid-operation included; in-flight data is discarded.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid mirrors s2_valid.
- Stage 1 (capture on an input transfer):
  - lo = in_sum[SPLIT-1:0] + in_carry[SPLIT-1:0], with carry c1 out of bit SPLIT-1.
  - Registers lo, c1, in_sum[WIDTH-1:SPLIT] and in_carry[WIDTH-1:SPLIT]; sets s1_valid.
- Stage 2 (advance when s1_valid && s2_can_load):
  - hi = s1_sum_hi + s1_carry_hi + c1.
  - out_result = {hi[WIDTH-SPLIT-1:0], lo}; out_cout = carry out of hi; sets s2_valid.
- Stall logic:
  - s2_can_load = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_can_load. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency and throughput: 2 cycles from input transfer to out_valid with no stall; one result per cycle sustained.
- Valid updates:
  - s1_valid clears when stage 1 advances without a new input.
  - s2_valid clears on an output transfer with no stage-1 advance.
  - Simultaneous advance and capture keeps both valid and moves data one stage.
- Full pipeline:
  - With s1 and s2 both valid and out_ready=0: in_ready=0 and all registers hold.
  - out_result and out_cout stay stable while out_valid && !out_ready.
- Empty pipeline: in_ready=1 regardless of out_ready.
- Wrap-around: the sum is modulo 2^WIDTH; the overflow bit appears only on out_cout.
- Ordering: results emerge strictly in input order; no drop or duplication under any valid/ready pattern.

Optional Feature:
- Macro: WTREE_FINAL_ADDER_ZERO_FLAG_EN.
- Defined:
  - Adds output port out_zero (1 bit), registered in stage 2 alongside out_result.
  - out_zero = 1 iff the WIDTH-bit result is 0, regardless of out_cout. It is computed as (lo==0) registered in stage 1, ANDed with (hi==0) in stage 2.
  - Reset value 0; held stable under stall like out_result.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic add, out_ready=1: sum=0x0000_0000_FFFF_FFFF, carry=0x1 -> two cycles later out_result=0x0000_0001_0000_0000, out_cout=0 (exercises the carry across SPLIT).
- Overflow: sum=0xFFFF_FFFF_FFFF_FFFF, carry=0x1 -> out_result=0, out_cout=1, out_zero=1 when the macro is defined.
- Back-pressure: stream 4 pairs (k, k<<1) for k=1..4 with out_ready=0 -> in_ready drops after 2 accepts. Raise out_ready -> results 3, 6, 9, 12 in order, no loss.
- Random valid/ready toggling for 1000 random pairs -> every result equals the reference sum mod 2^64 plus cout, in order, and outputs are stable while stalled.
- Reset mid-operation: assert reset asynchronously with 2 items in flight -> out_valid=0 and out_result=0 immediately, in_ready=1 after release, and no stale result emerges.
- Parameter sweep WIDTH=16, SPLIT=1 and SPLIT=15 with sum=0x7FFF, carry=0x0001 -> out_result=0x8000, out_cout=0.
